// File: rtl/ser_pkg.sv
// Shared types and constants for the serial deserializer slice.
package ser_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SHIFT  = 2'd1,
        PARITY = 2'd2
    } state_t;

    localparam logic DIR_LSB_FIRST = 1'b0;
    localparam logic DIR_MSB_FIRST = 1'b1;

endpackage

// File: rtl/ser_shift_reg.sv
// WIDTH-bit receive shift register with selectable shift direction.
// data_out shows either the next value (look_ahead=1) or the held value.
module ser_shift_reg
    import ser_pkg::*;
#(
    parameter int WIDTH = 4
) (
    input  logic             clock,
    input  logic             resetn,
    input  logic             clear,
    input  logic             shift_en,
    input  logic             dir,
    input  logic             serial_in,
    input  logic             look_ahead,
    output logic [WIDTH-1:0] data_out
);

    logic [WIDTH-1:0] sreg_q;
    logic [WIDTH-1:0] sreg_nxt;

    // MSB-first shifts toward the top so the first bit ends in [WIDTH-1]
    always_comb begin
        sreg_nxt = sreg_q;
        if (dir == DIR_MSB_FIRST) begin
            sreg_nxt = {sreg_q[WIDTH-2:0], serial_in};
        end else begin
            sreg_nxt = {serial_in, sreg_q[WIDTH-1:1]};
        end
    end

    // shift register storage
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            sreg_q <= '0;
        end else if (clear) begin
            sreg_q <= '0;
        end else if (shift_en) begin
            sreg_q <= sreg_nxt;
        end
    end

    assign data_out = look_ahead ? sreg_nxt : sreg_q;

endmodule

// File: rtl/serial_deserializer.sv
// Serial-to-parallel receiver with one-word output buffer and valid/ready.
// Optional even-parity bit after each word: define DESER_PARITY_EN.
//
// state  | meaning
// IDLE   | no partial word; next strobe is bit 0 and latches bit order
// SHIFT  | collecting data bits 1..WIDTH-1
// PARITY | all data bits in, waiting for the parity bit (DESER_PARITY_EN)
module serial_deserializer
    import ser_pkg::*;
#(
    parameter  int WIDTH = 4,
    localparam int CNTW  = $clog2(WIDTH + 1)
) (
    input  logic             clock,
    input  logic             resetn,
    input  logic             Clear,
    input  logic             SerialIn,
    input  logic             SerialValid,
    input  logic             MSBFirst,
    input  logic             OutReady,
    output logic [WIDTH-1:0] Data_OUT,
    output logic             OutValid,
    output logic             Overrun,
    output logic [CNTW-1:0]  BitCount,
    output logic             ParityErr
);

    localparam logic [CNTW-1:0] LAST_BIT = CNTW'(WIDTH - 1);

    state_t           state_q, state_d;
    logic [CNTW-1:0]  cnt_q, cnt_d;
    logic             dir_q, dir_d;
    logic             shift_dir;
    logic             shift_en;
    logic             complete;
    logic             accept;
    logic [WIDTH-1:0] word_c;

    assign accept = SerialValid && !Clear;

`ifdef DESER_PARITY_EN
    // the word is already fully shifted when the parity bit arrives
    localparam logic LOOK_AHEAD = 1'b0;
    logic perr_c;
    logic perr_q;
    assign perr_c    = (^word_c) ^ SerialIn;
    assign ParityErr = perr_q;
`else
    // the last data bit completes the word, so take the post-shift value
    localparam logic LOOK_AHEAD = 1'b1;
    assign ParityErr = 1'b0;
`endif

    ser_shift_reg #(
        .WIDTH (WIDTH)
    ) u_shift (
        .clock      (clock),
        .resetn     (resetn),
        .clear      (Clear),
        .shift_en   (shift_en),
        .dir        (shift_dir),
        .serial_in  (SerialIn),
        .look_ahead (LOOK_AHEAD),
        .data_out   (word_c)
    );

    // FSM, bit counter and direction register
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            dir_q   <= DIR_LSB_FIRST;
        end else if (Clear) begin
            state_q <= IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            dir_q   <= dir_d;
        end
    end

    // next-state; bit 0 uses MSBFirst directly since dir_q is not yet loaded
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        dir_d     = dir_q;
        shift_dir = dir_q;
        shift_en  = 1'b0;
        complete  = 1'b0;
        unique case (state_q)
            IDLE: begin
                shift_dir = MSBFirst;
                if (accept) begin
                    shift_en = 1'b1;
                    dir_d    = MSBFirst;
                    cnt_d    = CNTW'(1);
                    state_d  = SHIFT;
                end
            end
            SHIFT: begin
                if (accept) begin
                    shift_en = 1'b1;
                    if (cnt_q == LAST_BIT) begin
`ifdef DESER_PARITY_EN
                        cnt_d   = CNTW'(WIDTH);
                        state_d = PARITY;
`else
                        cnt_d    = '0;
                        state_d  = IDLE;
                        complete = 1'b1;
`endif
                    end else begin
                        cnt_d = cnt_q + CNTW'(1);
                    end
                end
            end
            PARITY: begin
                if (accept) begin
                    cnt_d    = '0;
                    state_d  = IDLE;
                    complete = 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    // output buffer: load on completion unless an unconsumed word would be lost
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            Data_OUT <= '0;
            OutValid <= 1'b0;
            Overrun  <= 1'b0;
`ifdef DESER_PARITY_EN
            perr_q   <= 1'b0;
`endif
        end else if (Clear) begin
            OutValid <= 1'b0;
            Overrun  <= 1'b0;
`ifdef DESER_PARITY_EN
            perr_q   <= 1'b0;
`endif
        end else if (complete) begin
            if (!OutValid || OutReady) begin
                Data_OUT <= word_c;
                OutValid <= 1'b1;
`ifdef DESER_PARITY_EN
                perr_q   <= perr_c;
`endif
            end else begin
                Overrun <= 1'b1;
            end
        end else if (OutValid && OutReady) begin
            OutValid <= 1'b0;
        end
    end

    assign BitCount = cnt_q;

endmodule

// File: tb/tb_serial_deserializer.sv
// Scoreboard bench for serial_deserializer: directed cases then random traffic.
`timescale 1ns/1ps
module tb_serial_deserializer;

    localparam int WIDTH = 4;
    localparam int CNTW  = $clog2(WIDTH + 1);

    logic             clock = 1'b0;
    logic             resetn = 1'b1;
    logic             Clear = 1'b0;
    logic             SerialIn = 1'b0;
    logic             SerialValid = 1'b0;
    logic             MSBFirst = 1'b0;
    logic             OutReady = 1'b0;
    logic [WIDTH-1:0] Data_OUT;
    logic             OutValid;
    logic             Overrun;
    logic [CNTW-1:0]  BitCount;
    logic             ParityErr;

    serial_deserializer #(.WIDTH(WIDTH)) dut (
        .clock       (clock),
        .resetn      (resetn),
        .Clear       (Clear),
        .SerialIn    (SerialIn),
        .SerialValid (SerialValid),
        .MSBFirst    (MSBFirst),
        .OutReady    (OutReady),
        .Data_OUT    (Data_OUT),
        .OutValid    (OutValid),
        .Overrun     (Overrun),
        .BitCount    (BitCount),
        .ParityErr   (ParityErr)
    );

    always #5 clock = ~clock;

    typedef struct {
        logic [WIDTH-1:0] word;
        logic             perr;
    } exp_t;

    exp_t sb_q[$];
    int   vectors = 0;
    int   miscompares = 0;

    // reference model: bits of the partial word in arrival order
    bit   m_bits[$];
    bit   m_msb = 1'b0;
    bit   m_valid = 1'b0;
    bit   m_ovr = 1'b0;
    bit   flush_q = 1'b0;
    bit   mon_en = 1'b0;
    logic            exp_valid = 1'b0;
    logic            exp_ovr = 1'b0;
    logic [CNTW-1:0] exp_cnt = '0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        vectors++;
        if (act !== req) begin
            miscompares++;
            $display("FAIL %s: got %0h, expected %0h at %0t", name, act, req, $time);
        end
    endtask

    // one clock of stimulus; called at posedge+1, model predicts the coming edge
    task automatic cycle(input bit clr, input bit sv, input bit si, input bit msb, input bit rdy);
        bit               done;
        logic [WIDTH-1:0] w;
        exp_t             e;
        bit               pb;
        if (flush_q) begin
            sb_q.delete();
            flush_q = 1'b0;
        end
        exp_valid   = m_valid;
        exp_ovr     = m_ovr;
        exp_cnt     = CNTW'(m_bits.size());
        Clear       = clr;
        SerialValid = sv;
        SerialIn    = si;
        MSBFirst    = msb;
        OutReady    = clr ? 1'b0 : rdy;
        done = 1'b0;
        pb   = 1'b0;
        if (clr) begin
            m_bits.delete();
            m_valid = 1'b0;
            m_ovr   = 1'b0;
            flush_q = 1'b1;
        end else begin
            if (sv) begin
`ifdef DESER_PARITY_EN
                if (m_bits.size() == WIDTH) begin
                    done = 1'b1;
                    pb   = si;
                end else begin
                    if (m_bits.size() == 0) m_msb = msb;
                    m_bits.push_back(si);
                end
`else
                if (m_bits.size() == 0) m_msb = msb;
                m_bits.push_back(si);
                if (m_bits.size() == WIDTH) done = 1'b1;
`endif
            end
            if (done) begin
                w = '0;
                for (int i = 0; i < WIDTH; i++) begin
                    if (m_msb) w[WIDTH-1-i] = m_bits[i];
                    else       w[i]         = m_bits[i];
                end
                e.word = w;
`ifdef DESER_PARITY_EN
                e.perr = (^w) ^ pb;
`else
                e.perr = 1'b0 & pb;
`endif
                m_bits.delete();
                if (!m_valid || rdy) begin
                    sb_q.push_back(e);
                    m_valid = 1'b1;
                end else begin
                    m_ovr = 1'b1;
                end
            end else if (m_valid && rdy) begin
                m_valid = 1'b0;
            end
        end
        @(posedge clock);
        #1;
    endtask

    // seq[WIDTH-1] is sent first; flip toggles MSBFirst after bit 0
    task automatic send_word(input logic [WIDTH-1:0] seq, input bit msb, input bit flip,
                             input bit rdy_mid, input bit rdy_last, input bit pbit);
        for (int i = 0; i < WIDTH; i++) begin
            bit last;
`ifdef DESER_PARITY_EN
            last = 1'b0;
`else
            last = (i == WIDTH - 1);
`endif
            cycle(1'b0, 1'b1, seq[WIDTH-1-i], (flip && i > 0) ? ~msb : msb,
                  last ? rdy_last : rdy_mid);
        end
`ifdef DESER_PARITY_EN
        cycle(1'b0, 1'b1, pbit, flip ? ~msb : msb, rdy_last);
`else
        if (pbit) begin end
`endif
    endtask

    task automatic idle(input int n, input bit rdy);
        for (int i = 0; i < n; i++) cycle(1'b0, 1'b0, 1'b0, 1'b0, rdy);
    endtask

    // monitor: outputs are stable at the falling edge; consume on valid&&ready
    always @(negedge clock) begin
        if (mon_en) begin
            check("OutValid", {31'b0, OutValid}, {31'b0, exp_valid});
            check("Overrun", {31'b0, Overrun}, {31'b0, exp_ovr});
            check("BitCount", 32'(BitCount), 32'(exp_cnt));
            if (OutValid) begin
                check("sb_has_word", {31'b0, sb_q.size() != 0}, 32'd1);
                if (sb_q.size() != 0) begin
                    check("Data_OUT", 32'(Data_OUT), 32'(sb_q[0].word));
                    check("ParityErr", {31'b0, ParityErr}, {31'b0, sb_q[0].perr});
                    if (OutReady) void'(sb_q.pop_front());
                end
            end
        end
    end

    initial begin
        #1 resetn = 1'b0;
        #1;
        check("reset_Data_OUT", 32'(Data_OUT), 32'd0);
        check("reset_OutValid", {31'b0, OutValid}, 32'd0);
        check("reset_Overrun", {31'b0, Overrun}, 32'd0);
        check("reset_BitCount", 32'(BitCount), 32'd0);
        check("reset_ParityErr", {31'b0, ParityErr}, 32'd0);
        @(posedge clock);
        #1 resetn = 1'b1;
        mon_en = 1'b1;

        // MSB-first 1,0,1,1 -> 1011; then wrong parity; then LSB-first with toggling
        send_word(4'b1011, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1);
        idle(2, 1'b1);
        send_word(4'b1011, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0);
        idle(2, 1'b1);
        send_word(4'b1011, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1);
        idle(2, 1'b1);

        // overrun: A held, 5 dropped, then Clear
        send_word(4'hA, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        send_word(4'h5, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        idle(2, 1'b0);
        cycle(1'b1, 1'b1, 1'b1, 1'b1, 1'b0);
        idle(2, 1'b1);

        // replacement: 3 pending, C completes on an edge with OutReady=1
        send_word(4'h3, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        send_word(4'hC, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
        idle(3, 1'b1);

        // async reset mid-word with a word pending
        send_word(4'h9, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
        cycle(1'b0, 1'b1, 1'b1, 1'b1, 1'b0);
        cycle(1'b0, 1'b1, 1'b0, 1'b1, 1'b0);
        mon_en = 1'b0;
        SerialValid = 1'b0;
        resetn = 1'b0;
        #1;
        check("midreset_BitCount", 32'(BitCount), 32'd0);
        check("midreset_OutValid", {31'b0, OutValid}, 32'd0);
        #1 resetn = 1'b1;
        m_bits.delete();
        m_valid = 1'b0;
        m_ovr   = 1'b0;
        flush_q = 1'b0;
        sb_q.delete();
        @(posedge clock);
        #1 mon_en = 1'b1;
        send_word(4'b0110, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0);
        idle(2, 1'b1);

        // random traffic
        for (int n = 0; n < 600; n++) begin
            cycle($urandom_range(0, 49) == 0, $urandom_range(0, 1) == 1,
                  $urandom_range(0, 1) == 1, $urandom_range(0, 1) == 1,
                  $urandom_range(0, 9) < 6);
        end
        idle(3, 1'b1);
        mon_en = 1'b0;
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
